// File: rtl/control_unit_fsm_pkg.sv
// Shared definitions for the multicycle RV32I control unit: opcodes,
// FSM state encodings, instruction classes, RF write-back mux selects
// and the bundle of registered datapath strobes.
package control_unit_fsm_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Encodings are visible on state_dbg, listed in sequencing order.
  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TRAP      = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_OP,
    CLS_OP_IMM,
    CLS_LOAD,
    CLS_STORE,
    CLS_AUIPC,
    CLS_JAL,
    CLS_JALR,
    CLS_BRANCH
  } instr_class_t;

  localparam logic [1:0] RF_SEL_MEM   = 2'd0;
  localparam logic [1:0] RF_SEL_ALU   = 2'd1;
  localparam logic [1:0] RF_SEL_PC4   = 2'd2;
  localparam logic [1:0] RF_SEL_PCADD = 2'd3;

  typedef struct packed {
    logic       sub;
    logic       din2_sel;
    logic [1:0] rf_din_sel;
    logic       we_rf;
    logic       we_mem;
    logic       load_pc;
    logic       pc_next_sel;
    logic       pc_adder_sel;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/control_unit_fsm_instr_decoder.sv
// Combinational instruction classifier for the control unit.
// Maps the instruction register onto an instruction class and flags
// anything the sequencer cannot execute (lui, system, fence, unknown).
// Build option: CTRL_BRANCH_EN makes beq/bne legal; otherwise every
// branch opcode is reported illegal.
module control_unit_fsm_instr_decoder
  import control_unit_fsm_pkg::*;
#(
  parameter int INSTR_W = 32
) (
  input  logic [INSTR_W-1:0] ir,
  output instr_class_t       cls,
  output logic               sub_op,
  output logic               bne,
  output logic               illegal
);

  logic unused_ir_bits;

  // Opcode classification and legality
  always_comb begin
    cls     = CLS_OP;
    illegal = 1'b0;
    case (ir[6:0])
      OPC_OP:     cls = CLS_OP;
      OPC_OP_IMM: cls = CLS_OP_IMM;
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  cls = CLS_STORE;
      OPC_AUIPC:  cls = CLS_AUIPC;
      OPC_JAL:    cls = CLS_JAL;
      OPC_JALR:   cls = CLS_JALR;
      OPC_BRANCH: begin
        cls = CLS_BRANCH;
`ifdef CTRL_BRANCH_EN
        // only beq (000) and bne (001) are sequenced
        illegal = (ir[14:13] != 2'b00);
`else
        illegal = 1'b1;
`endif
      end
      default:    illegal = 1'b1;
    endcase
  end

  // Subtract only for R-type add/sub with funct7[5] set
  assign sub_op = (ir[6:0] == OPC_OP) && (ir[14:12] == 3'b000) && ir[30];
  assign bne    = ir[12];

  // Register fields and immediates belong to the datapath
  assign unused_ir_bits = ^{ir[INSTR_W-1:31], ir[29:15], ir[11:7]};

endmodule

// File: rtl/control_unit_fsm.sv
// Multicycle RV32I control unit sequencing FETCH/DECODE/EXECUTE/MEMORY/
// WRITEBACK and driving every datapath strobe. Strobes are registered
// from the next state; only the branch pc_next_sel (needs zero) and the
// store-completion load_pc (needs mem_ready) are resolved in-cycle.
// Build option: CTRL_BRANCH_EN enables beq/bne; undefined, branches trap
// and zero is not used.
//
//  state     | meaning
//  ----------+-----------------------------------------------------
//  FETCH     | ir_load=1, instr captured into IR
//  DECODE    | no strobes, IR classified, illegal -> TRAP
//  EXECUTE   | ALU/branch operation, branch retires here
//  MEMORY    | load waits / store writes until mem_ready or timeout
//  WRITEBACK | WE_RF and load_pc for one cycle, then FETCH
//  TRAP      | illegal=1, all strobes low until reset
module control_unit_fsm
  import control_unit_fsm_pkg::*;
#(
  parameter int INSTR_W     = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               ir_load,
  output logic               sub,
  output logic               ULA_din2_sel,
  output logic [1:0]         RF_din_sel,
  output logic               WE_RF,
  output logic               WE_MEM,
  output logic               load_pc,
  output logic               pc_next_sel,
  output logic               pc_adder_sel,
  output logic               illegal,
  output logic [2:0]         state_dbg
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t             state, state_nxt;
  logic [INSTR_W-1:0] ir, ir_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  ctrl_t              ctrl_q, ctrl_nxt;
  instr_class_t       cls;
  logic               dec_sub, dec_bne, dec_illegal;
  logic               branch_taken;

  control_unit_fsm_instr_decoder #(
    .INSTR_W (INSTR_W)
  ) u_decoder (
    .ir      (ir),
    .cls     (cls),
    .sub_op  (dec_sub),
    .bne     (dec_bne),
    .illegal (dec_illegal)
  );

  // Next state, IR capture and memory-stall counter
  always_comb begin
    state_nxt = state;
    ir_nxt    = ir;
    cnt_nxt   = cnt;
    case (state)
      ST_FETCH: begin
        state_nxt = ST_DECODE;
        ir_nxt    = instr;
      end
      ST_DECODE:    state_nxt = dec_illegal ? ST_TRAP : ST_EXECUTE;
      ST_EXECUTE: begin
        cnt_nxt = '0;
        case (cls)
          CLS_LOAD, CLS_STORE: state_nxt = ST_MEMORY;
          CLS_BRANCH:          state_nxt = ST_FETCH;
          default:             state_nxt = ST_WRITEBACK;
        endcase
      end
      ST_MEMORY: begin
        // a ready response wins over a timeout in the same cycle
        if (mem_ready) begin
          state_nxt = (cls == CLS_LOAD) ? ST_WRITEBACK : ST_FETCH;
        end else if (MEM_TIMEOUT != 0) begin
          if (cnt == CNT_LAST) state_nxt = ST_TRAP;
          else                 cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      ST_WRITEBACK: state_nxt = ST_FETCH;
      ST_TRAP:      state_nxt = ST_TRAP;
      default:      state_nxt = ST_TRAP;
    endcase
  end

  // Strobes for the state being entered, so they appear registered
  always_comb begin
    ctrl_nxt = CTRL_IDLE;
    case (state_nxt)
      ST_EXECUTE: begin
        case (cls)
          CLS_OP:                          ctrl_nxt.sub = dec_sub;
          CLS_OP_IMM, CLS_LOAD, CLS_STORE: ctrl_nxt.din2_sel = 1'b1;
          CLS_BRANCH: begin
            ctrl_nxt.sub          = 1'b1;
            ctrl_nxt.pc_adder_sel = 1'b1;
            ctrl_nxt.load_pc      = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEMORY:    ctrl_nxt.we_mem = (cls == CLS_STORE);
      ST_WRITEBACK: begin
        ctrl_nxt.we_rf   = 1'b1;
        ctrl_nxt.load_pc = 1'b1;
        case (cls)
          CLS_LOAD:  ctrl_nxt.rf_din_sel = RF_SEL_MEM;
          CLS_AUIPC: begin
            ctrl_nxt.rf_din_sel   = RF_SEL_PCADD;
            ctrl_nxt.pc_adder_sel = 1'b1;
          end
          CLS_JAL: begin
            ctrl_nxt.rf_din_sel   = RF_SEL_PC4;
            ctrl_nxt.pc_next_sel  = 1'b1;
            ctrl_nxt.pc_adder_sel = 1'b1;
          end
          CLS_JALR: begin
            ctrl_nxt.rf_din_sel  = RF_SEL_PC4;
            ctrl_nxt.pc_next_sel = 1'b1;
          end
          default:   ctrl_nxt.rf_din_sel = RF_SEL_ALU;
        endcase
      end
      ST_TRAP:      ctrl_nxt.illegal = 1'b1;
      default: ;
    endcase
  end

  // State, IR, counter and strobe registers; reset aborts any access
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state  <= ST_FETCH;
      ir     <= '0;
      cnt    <= '0;
      ctrl_q <= CTRL_IDLE;
    end else begin
      state  <= state_nxt;
      ir     <= ir_nxt;
      cnt    <= cnt_nxt;
      ctrl_q <= ctrl_nxt;
    end
  end

`ifdef CTRL_BRANCH_EN
  // beq takes the branch on zero, bne on not-zero
  assign branch_taken = (state == ST_EXECUTE) && (cls == CLS_BRANCH) && (zero ^ dec_bne);
`else
  logic unused_branch_inputs;
  assign unused_branch_inputs = zero ^ dec_bne;
  assign branch_taken         = 1'b0;
`endif

  // ir_load is gated by reset so every output is low while reset is held
  assign ir_load      = (state == ST_FETCH) && reset;
  assign sub          = ctrl_q.sub;
  assign ULA_din2_sel = ctrl_q.din2_sel;
  assign RF_din_sel   = ctrl_q.rf_din_sel;
  assign WE_RF        = ctrl_q.we_rf;
  assign WE_MEM       = ctrl_q.we_mem;
  assign load_pc      = ctrl_q.load_pc | (ctrl_q.we_mem & mem_ready);
  assign pc_next_sel  = ctrl_q.pc_next_sel | branch_taken;
  assign pc_adder_sel = ctrl_q.pc_adder_sel;
  assign illegal      = ctrl_q.illegal;
  assign state_dbg    = state;

endmodule

// File: tb/tb_control_unit_fsm.sv
// Directed plus randomized bench for control_unit_fsm. Each instruction is
// expanded into its expected phase sequence and per-phase strobes derived
// from the instruction-level rules; outputs are compared every cycle.
`timescale 1ns/1ps
module tb_control_unit_fsm;

  localparam int MEM_TIMEOUT = 16;
  // phases in sequencing order; state_dbg reports this index
  localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4, P_T = 5;
  localparam int K_R = 0, K_I = 1, K_LD = 2, K_SD = 3, K_AUIPC = 4,
                 K_JAL = 5, K_JALR = 6, K_BR = 7, K_ILL = 8;

  typedef struct packed {
    logic       ir_load;
    logic       sub;
    logic       din2;
    logic [1:0] rf;
    logic       we_rf;
    logic       we_mem;
    logic       load_pc;
    logic       next;
    logic       adder;
    logic       illegal;
    logic [2:0] st;
  } exp_t;

  logic        CLK = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        zero, mem_ready;
  logic        ir_load, sub, ULA_din2_sel, WE_RF, WE_MEM, load_pc;
  logic        pc_next_sel, pc_adder_sel, illegal;
  logic [1:0]  RF_din_sel;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  control_unit_fsm #(
    .INSTR_W     (32),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .CLK          (CLK),
    .reset        (reset),
    .instr        (instr),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .ir_load      (ir_load),
    .sub          (sub),
    .ULA_din2_sel (ULA_din2_sel),
    .RF_din_sel   (RF_din_sel),
    .WE_RF        (WE_RF),
    .WE_MEM       (WE_MEM),
    .load_pc      (load_pc),
    .pc_next_sel  (pc_next_sel),
    .pc_adder_sel (pc_adder_sel),
    .illegal      (illegal),
    .state_dbg    (state_dbg)
  );

  function automatic int kind_of(input logic [31:0] ins);
    case (ins[6:0])
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b0000011: return K_LD;
      7'b0100011: return K_SD;
      7'b0010111: return K_AUIPC;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
`ifdef CTRL_BRANCH_EN
      7'b1100011: return (ins[14:12] == 3'b000 || ins[14:12] == 3'b001) ? K_BR : K_ILL;
`endif
      default:    return K_ILL;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input int ph, input logic z, input logic rdy);
    exp_t e;
    int   k;
    e    = '0;
    k    = kind_of(ins);
    e.st = 3'(ph);
    case (ph)
      P_F: e.ir_load = 1'b1;
      P_E: begin
        if (k == K_R) e.sub = (ins[14:12] == 3'b000) && ins[30];
        if (k == K_I || k == K_LD || k == K_SD) e.din2 = 1'b1;
        if (k == K_BR) begin
          e.sub     = 1'b1;
          e.adder   = 1'b1;
          e.load_pc = 1'b1;
          e.next    = (ins[14:12] == 3'b000) ? z : ~z;
        end
      end
      P_M: if (k == K_SD) begin
        e.we_mem  = 1'b1;
        e.load_pc = rdy;
      end
      P_W: begin
        e.we_rf   = 1'b1;
        e.load_pc = 1'b1;
        if (k == K_R || k == K_I) e.rf = 2'd1;
        if (k == K_AUIPC) begin e.rf = 2'd3; e.adder = 1'b1; end
        if (k == K_JAL)   begin e.rf = 2'd2; e.next = 1'b1; e.adder = 1'b1; end
        if (k == K_JALR)  begin e.rf = 2'd2; e.next = 1'b1; end
      end
      P_T: e.illegal = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic check(input exp_t e, input string tag);
    exp_t o;
    o = {ir_load, sub, ULA_din2_sel, RF_din_sel, WE_RF, WE_MEM, load_pc,
         pc_next_sel, pc_adder_sel, illegal, state_dbg};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b (ir_load sub din2 rf[2] we_rf we_mem load_pc next adder illegal st[3])",
             tag, o, e);
    end
  endtask

  task automatic drive_check(input logic [31:0] ins, input int ph, input logic rdy,
                             input logic z, input string tag);
    instr     = (ph == P_F) ? ins : $urandom();
    zero      = z;
    mem_ready = rdy;
    #1;
    check(model(ins, ph, z, rdy), tag);
  endtask

  task automatic do_reset(input string name);
    reset = 1'b0;
    #1;
    check('0, {name, ".rst"});
    @(negedge CLK);
    reset = 1'b1;
  endtask

  // stalls: MEMORY cycles with mem_ready low before it rises
  task automatic run_instr(input logic [31:0] ins, input int stalls, input int zero_force,
                           input string name);
    int   ph[$];
    int   k, m_idx, mcyc;
    logic rdy, z;
    k = kind_of(ins);
    ph.push_back(P_F);
    ph.push_back(P_D);
    if (k == K_ILL) begin
      repeat (3) ph.push_back(P_T);
    end else begin
      ph.push_back(P_E);
      if (k == K_LD || k == K_SD) begin
        mcyc = (stalls >= MEM_TIMEOUT) ? MEM_TIMEOUT : stalls + 1;
        repeat (mcyc) ph.push_back(P_M);
        if (stalls >= MEM_TIMEOUT) repeat (3) ph.push_back(P_T);
        else if (k == K_LD)        ph.push_back(P_W);
      end else if (k != K_BR) begin
        ph.push_back(P_W);
      end
    end
    m_idx = 0;
    foreach (ph[i]) begin
      if (ph[i] == P_M) begin
        rdy = (m_idx >= stalls);
        m_idx++;
      end else begin
        rdy = 1'($urandom_range(0, 1));
      end
      z = (zero_force >= 0) ? 1'(zero_force) : 1'($urandom_range(0, 1));
      drive_check(ins, ph[i], rdy, z, $sformatf("%s.c%0d", name, i));
      @(negedge CLK);
    end
    if (ph[ph.size() - 1] == P_T) do_reset(name);
  endtask

  initial begin
    logic [6:0]  opc [9];
    logic [6:0]  bad [4];
    logic [31:0] ins;
    int          k, stalls;

    opc = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b0010111,
            7'b1101111, 7'b1100111, 7'b1100011, 7'b0110111};
    bad = '{7'b0110111, 7'b1110011, 7'b0001111, 7'b1111111};

    reset     = 1'b0;
    instr     = '0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    #1;
    check('0, "reset.async");
    @(negedge CLK);
    check('0, "reset.held");
    reset = 1'b1;

    run_instr(32'h002081B3, 0, -1, "add");
    run_instr(32'h40208233, 0, -1, "sub");
    run_instr(32'h0000A183, 3, -1, "ld_wait3");
    run_instr(32'h008000EF, 0, -1, "jal");
    run_instr(32'h000080E7, 0, -1, "jalr");
    run_instr(32'h00001097, 0, -1, "auipc");
    run_instr(32'h00208463, 0, 1, "beq_z1");
    run_instr(32'h00208463, 0, 0, "beq_z0");
    run_instr(32'h00209463, 0, 1, "bne_z1");
    run_instr(32'h0020C463, 0, 0, "blt");
    run_instr(32'h000010B7, 0, -1, "lui");
    run_instr(32'h00000073, 0, -1, "ecall");
    run_instr(32'h0000000F, 0, -1, "fence");
    run_instr(32'h0020B023, 0, -1, "sd_fast");
    run_instr(32'h0020B023, MEM_TIMEOUT - 1, -1, "sd_wait15");
    run_instr(32'h0020B023, MEM_TIMEOUT, -1, "sd_timeout");
    run_instr(32'h0000A183, MEM_TIMEOUT, -1, "ld_timeout");

    // reset while a store is writing memory
    ins = 32'h0020B023;
    drive_check(ins, P_F, 1'b0, 1'b0, "mid_sd.F"); @(negedge CLK);
    drive_check(ins, P_D, 1'b0, 1'b0, "mid_sd.D"); @(negedge CLK);
    drive_check(ins, P_E, 1'b0, 1'b0, "mid_sd.E"); @(negedge CLK);
    drive_check(ins, P_M, 1'b0, 1'b0, "mid_sd.M");
    #1 reset = 1'b0;
    #1 check('0, "mid_sd.rst_async");
    @(negedge CLK);
    check('0, "mid_sd.rst_held");
    reset = 1'b1;
    run_instr(32'h002081B3, 0, -1, "post_rst_add");

    for (int n = 0; n < 200; n++) begin
      k   = $urandom_range(0, 8);
      ins = $urandom();
      ins[6:0] = (k == K_ILL) ? bad[$urandom_range(0, 3)] : opc[k];
      stalls = ($urandom_range(0, 9) == 0) ? MEM_TIMEOUT : $urandom_range(0, 4);
      run_instr(ins, stalls, -1, $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
